// File: rtl/local_inj_ctrl_pkg.sv
// Purpose: shared widths, flit field positions and FSM encoding for the local injection controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package local_inj_ctrl_pkg;

  // Flit layout: VALID is the MSB; TIME occupies TIME_WIDTH bits starting at TIME_POS.
  localparam int DATA_WIDTH = 32;
  localparam int VALID_POS  = 31;
  localparam int TIME_WIDTH = 8;
  localparam int TIME_POS   = 23;
  // Timestamps run 0..MAX_TIME-1; MAX_TIME itself is reserved and never issued.
  localparam int MAX_TIME   = 100;

  localparam int INJ_DEPTH     = 4;
  localparam int DEF_STARVE_TH = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OFFER    = 2'd1,
    ST_THROTTLE = 2'd2,
    ST_STARVE   = 2'd3
  } inj_state_e;

endpackage

// File: rtl/local_inj_ctrl_fifo.sv
// Purpose: circular injection buffer with wrap-bit pointers, head read port and count.
// Latency: a pushed entry is visible at head_dat / count the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
//
// Ports:
//   clk, reset_n       clock, async active-low reset (pointers only)
//   push, wr_dat       write wr_dat at the tail
//   pop                retire the head entry
//   head_dat           current head entry (undefined contents when count==0)
//   count              number of stored entries, 0..DEPTH
module inj_fifo
  import local_inj_ctrl_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int DEPTH = INJ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DW-1:0]            wr_dat,
  input  logic                     pop,
  output logic [DW-1:0]            head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count>0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];
  assign count    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/local_inj_ctrl.sv
// Purpose: router local-port injection/ejection controller (timestamping, throttle, starvation).
// Latency: a flit pushed into an empty buffer is offered the next cycle; eject path is 1 cycle.
// Backpressure: pe_ready is registered (buffer not full next cycle); ejection has none.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   pe_flit/pe_valid    PE injection request, accepted when pe_ready=1
//   pe_ready            buffer can take a flit this cycle
//   inj_flit            head offered to local stage in_4 (zero when nothing offered)
//   inj_grant           local stage accepted inj_flit this cycle
//   throttle            congestion request to hold injection back
//   eject_in            local stage out_4
//   ej_flit/ej_valid    registered ejected flit to the PE
//   starve              head has waited too long and overrides throttle
//   occupancy           buffered flit count
module local_inj_ctrl
  import local_inj_ctrl_pkg::*;
#(
  parameter int DW        = DATA_WIDTH,
  parameter int DEPTH     = INJ_DEPTH,
  parameter int TW        = TIME_WIDTH,
  parameter int STARVE_TH = DEF_STARVE_TH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DW-1:0]            pe_flit,
  input  logic                     pe_valid,
  output logic                     pe_ready,
  output logic [DW-1:0]            inj_flit,
  input  logic                     inj_grant,
  input  logic                     throttle,
  input  logic [DW-1:0]            eject_in,
  output logic [DW-1:0]            ej_flit,
  output logic                     ej_valid,
  output logic                     starve,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(STARVE_TH + 1);
  localparam logic [TW-1:0] TS_LAST  = TW'(MAX_TIME - 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(STARVE_TH);

  inj_state_e    state_q, state_d;
  logic [TW-1:0] ts_q, ts_d;
  logic [WW-1:0] wait_q, wait_d, wait_inc;
  logic          pe_ready_q, pe_ready_d;
  logic          starve_q, starve_d;
  logic [DW-1:0] ej_flit_q, ej_flit_d;
  logic          ej_valid_q, ej_valid_d;

  logic          push, pop, offer;
  logic [DW-1:0] wr_flit, head_dat;
  logic [CW-1:0] count, count_nxt;

  inj_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .wr_dat   (wr_flit),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  // Stored flits always carry VALID=1 and the enqueue-cycle timestamp.
  always_comb begin
    wr_flit = pe_flit;
    wr_flit[VALID_POS] = 1'b1;
    wr_flit[TIME_POS +: TW] = ts_q;
  end

  // Offer depends only on registered state, so inj_grant never feeds back into inj_flit.
  assign offer    = (state_q == ST_OFFER) || (state_q == ST_STARVE);
  assign inj_flit = offer ? head_dat : '0;
  assign push     = pe_valid & pe_ready_q;
  assign pop      = inj_grant & inj_flit[VALID_POS];

  assign count_nxt = count + CW'(push) - CW'(pop);
  assign wait_inc  = (wait_q == WAIT_SAT) ? wait_q : wait_q + 1'b1;

  always_comb begin
    ts_d = (ts_q == TS_LAST) ? '0 : ts_q + 1'b1;
  end

  // Injection FSM. The wait counter measures how long the current head has been
  // queued without a grant; it restarts at 0 whenever a new flit becomes head.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (count_nxt != '0) state_d = throttle ? ST_THROTTLE : ST_OFFER;
      end
      ST_OFFER: begin
        if (pop) begin
          wait_d = '0;
          if (count_nxt == '0) state_d = ST_IDLE;
          else                 state_d = throttle ? ST_THROTTLE : ST_OFFER;
        end else begin
          wait_d = wait_inc;
          if (wait_inc >= WAIT_SAT) state_d = ST_STARVE;
          else if (throttle)        state_d = ST_THROTTLE;
        end
      end
      ST_THROTTLE: begin
        wait_d = wait_inc;
        if (wait_inc >= WAIT_SAT) state_d = ST_STARVE;
        else if (!throttle)       state_d = ST_OFFER;
      end
      ST_STARVE: begin
        wait_d = wait_inc;
        if (pop) begin
          wait_d = '0;
          if (count_nxt == '0) state_d = ST_IDLE;
          else                 state_d = throttle ? ST_THROTTLE : ST_OFFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Ready looks at next-cycle occupancy so a full buffer can never be pushed.
  always_comb begin
    pe_ready_d = (count_nxt < CW'(DEPTH));
    starve_d   = (state_d == ST_STARVE);
    ej_valid_d = eject_in[VALID_POS];
    ej_flit_d  = eject_in[VALID_POS] ? eject_in : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      wait_q     <= '0;
      pe_ready_q <= 1'b0;
      starve_q   <= 1'b0;
      ej_flit_q  <= '0;
      ej_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      wait_q     <= wait_d;
      pe_ready_q <= pe_ready_d;
      starve_q   <= starve_d;
      ej_flit_q  <= ej_flit_d;
      ej_valid_q <= ej_valid_d;
    end
  end

  assign pe_ready  = pe_ready_q;
  assign starve    = starve_q;
  assign ej_flit   = ej_flit_q;
  assign ej_valid  = ej_valid_q;
  assign occupancy = count;

endmodule
